// File: rtl/host_if_pkg.sv
// Shared types and constants for the host-interface switch.
package host_if_pkg;

    // Mode FSM states
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_FLUSH  = 2'd2,
        ST_SWITCH = 2'd3
    } sw_state_t;

    // Host channel codes
    localparam int unsigned MODE_SFIFO = 0;
    localparam int unsigned MODE_SPI   = 1;
    localparam int unsigned MODE_UART  = 2;

    // Width of the saturating dropped-byte counter
    localparam int unsigned DROP_W = 8;

    // Saturating add used by the drop counter
    function automatic logic [DROP_W-1:0] sat_add(input logic [DROP_W-1:0] a,
                                                 input logic [DROP_W-1:0] b);
        logic [DROP_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[DROP_W] ? {DROP_W{1'b1}} : s[DROP_W-1:0];
    endfunction

endpackage

// File: rtl/host_if_switch_if.sv
// Channel-side and core-side FIFO handshakes of the host-interface switch.
interface host_if_switch_if #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned DW     = 8
);
    logic [NUM_CH-1:0]    ch_rx_rd_en;
    logic [NUM_CH*DW-1:0] ch_rx_dout;
    logic [NUM_CH-1:0]    ch_rx_empty;
    logic [NUM_CH-1:0]    ch_tx_rd_en;
    logic [NUM_CH*DW-1:0] ch_tx_din;
    logic [NUM_CH-1:0]    ch_tx_empty;
    logic                 rx_fifo_rd_en;
    logic [DW-1:0]        rx_fifo_dout;
    logic                 rx_fifo_empty;
    logic                 tx_fifo_rd_en;
    logic [DW-1:0]        tx_fifo_din;
    logic                 tx_fifo_empty;

    // Switch side
    modport master (
        output ch_rx_rd_en, input ch_rx_dout, input ch_rx_empty,
        input ch_tx_rd_en, output ch_tx_din, output ch_tx_empty,
        input rx_fifo_rd_en, output rx_fifo_dout, output rx_fifo_empty,
        output tx_fifo_rd_en, input tx_fifo_din, input tx_fifo_empty
    );

    // PHY engines and core FIFOs
    modport slave (
        input ch_rx_rd_en, output ch_rx_dout, output ch_rx_empty,
        output ch_tx_rd_en, input ch_tx_din, input ch_tx_empty,
        output rx_fifo_rd_en, input rx_fifo_dout, input rx_fifo_empty,
        input tx_fifo_rd_en, output tx_fifo_din, output tx_fifo_empty
    );
endinterface

// File: rtl/host_if_txbuf.sv
// DEPTH x DW first-word-fall-through TX prefetch buffer with synchronous flush.
module host_if_txbuf #(
    parameter  int unsigned DEPTH = 4,
    parameter  int unsigned DW    = 8,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [DW-1:0]    din,
    input  logic             pop,
    input  logic             flush,
    output logic [DW-1:0]    dout,
    output logic [CNT_W-1:0] count
);
    logic [DW-1:0]    mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             wr;
    logic             rd;

    assign wr   = push & (count != CNT_W'(DEPTH));
    assign rd   = pop & (count != '0);
    assign dout = mem[rd_ptr];

    // Storage array, no reset needed
    always_ff @(posedge clk) begin
        if (wr) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers and occupancy; flush overrides push/pop
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr) wr_ptr <= wr_ptr + PTR_W'(1);
            if (rd) rd_ptr <= rd_ptr + PTR_W'(1);
            if (wr && !rd)      count <= count + CNT_W'(1);
            else if (rd && !wr) count <= count - CNT_W'(1);
        end
    end
endmodule

// File: rtl/host_if_switch.sv
// N-channel host-interface switch: RX mux, TX prefetch, glitch-free mode change.
module host_if_switch
    import host_if_pkg::*;
#(
    parameter  int unsigned NUM_CH   = 4,
    parameter  int unsigned DW       = 8,
    parameter  int unsigned DEPTH    = 4,
    parameter  int unsigned DEF_MODE = MODE_SFIFO,
    parameter  int unsigned DRAIN_TO = 1024,
    localparam int unsigned SEL_W    = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [SEL_W-1:0]  req_mode,
    output logic [SEL_W-1:0]  active_mode,
    output logic              switching,
    output logic              mode_err,
    output logic [DROP_W-1:0] drop_cnt,
    host_if_switch_if.master  bus
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned TMR_W = $clog2(DRAIN_TO + 1);
    localparam int unsigned REQ_W = SEL_W + 1;

    sw_state_t            state;
    logic [SEL_W-1:0]     target;
    logic [TMR_W-1:0]     timer;
    logic [CNT_W-1:0]     count;
    logic [DW-1:0]        head;
    logic                 run;
    logic                 push;
    logic                 pop;
    logic                 flush;
    logic                 req_valid;
    logic [NUM_CH-1:0]    rx_rd_en;
    logic [NUM_CH-1:0]    tx_empty;
    logic [DW-1:0]        rx_dout;
    logic                 rx_empty;

    // Datapath only open in RUN and never while reset is held
    assign run       = reset_n & (state == ST_RUN);
    assign req_valid = REQ_W'(req_mode) < REQ_W'(NUM_CH);
    assign push      = run & ~bus.tx_fifo_empty & (count < CNT_W'(DEPTH));
    assign pop       = bus.ch_tx_rd_en[active_mode] & (count != '0);
    assign flush     = (state == ST_FLUSH);
    assign switching = (state != ST_RUN);

    assign bus.tx_fifo_rd_en = push;
    assign bus.ch_tx_din     = {NUM_CH{head}};
    assign bus.ch_rx_rd_en   = rx_rd_en;
    assign bus.ch_tx_empty   = tx_empty;
    assign bus.rx_fifo_dout  = rx_dout;
    assign bus.rx_fifo_empty = rx_empty;

    host_if_txbuf #(.DEPTH(DEPTH), .DW(DW)) u_txbuf (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .din     (bus.tx_fifo_din),
        .pop     (pop),
        .flush   (flush),
        .dout    (head),
        .count   (count)
    );

    // Zero-latency RX mux and per-channel TX empty view
    always_comb begin
        rx_dout  = '0;
        rx_empty = 1'b1;
        rx_rd_en = '0;
        tx_empty = '1;
        for (int k = 0; k < NUM_CH; k++) begin
            if (SEL_W'(k) == active_mode) begin
                rx_dout     = bus.ch_rx_dout[k*DW +: DW];
                rx_empty    = ~run | bus.ch_rx_empty[k];
                rx_rd_en[k] = run & bus.rx_fifo_rd_en & ~bus.ch_rx_empty[k];
                tx_empty[k] = (count == '0);
            end
        end
    end

    // Mode-change FSM: drain old channel, flush on timeout, then switch
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_RUN;
            active_mode <= SEL_W'(DEF_MODE);
            target      <= SEL_W'(DEF_MODE);
            timer       <= '0;
            mode_err    <= 1'b0;
            drop_cnt    <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (!req_valid) begin
                        mode_err <= 1'b1;
                    end else if (req_mode != active_mode) begin
                        target <= req_mode;
                        timer  <= '0;
                        state  <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (count == '0) begin
                        state <= ST_SWITCH;
                    end else if (timer == TMR_W'(DRAIN_TO - 1)) begin
                        state <= ST_FLUSH;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                ST_FLUSH: begin
                    drop_cnt <= sat_add(drop_cnt, DROP_W'(count));
                    state    <= ST_SWITCH;
                end
                ST_SWITCH: begin
                    active_mode <= target;
                    state       <= ST_RUN;
                end
                default: state <= ST_RUN;
            endcase
        end
    end
endmodule
